// File: rtl/kernel_host_pkg.sv
// Shared types and widths for the kernel host controller: the host-side FSM
// states, the dump-engine states, and the port widths derived from the memory address widths.
package kernel_host_pkg;

    localparam int AddressWidth_imem = 6;
    localparam int AddressWidth_dmem = 5;
    localparam int ProgLenWidth      = AddressWidth_imem + 1;
    localparam int DumpLenWidth      = AddressWidth_dmem + 1;
    localparam int CycleCountWidth   = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        DUMP,
        FIN
    } hostState_t;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD,
        RD_DONE
    } readState_t;

endpackage

// File: rtl/dump_reader.sv
// Dmem read-back engine: issues one port-B read, registers the returned word,
// then holds it on the dump stream until the host accepts it.
module dump_reader
    import kernel_host_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         start,
    input  logic [DumpLenWidth-1:0]      wordCount,
    output logic [AddressWidth_dmem-1:0] dmemRdAddress,
    output logic                         dmemRdCe,
    input  logic [DataWidth-1:0]         dmemRdQ,
    output logic                         dumpValid,
    output logic [DataWidth-1:0]         dumpData,
    input  logic                         dumpReady,
    output logic                         done,
    output readState_t                   dbgState
);

    readState_t              state, stateNext;
    logic [DumpLenWidth-1:0] wordIdx, wordIdxNext, nextIdx;
    logic [DataWidth-1:0]    dataNext;
    logic                    validNext;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state     <= RD_IDLE;
            wordIdx   <= '0;
            dumpData  <= '0;
            dumpValid <= 1'b0;
        end else begin
            state     <= stateNext;
            wordIdx   <= wordIdxNext;
            dumpData  <= dataNext;
            dumpValid <= validNext;
        end
    end

    always_comb begin
        stateNext     = state;
        wordIdxNext   = wordIdx;
        dataNext      = dumpData;
        validNext     = dumpValid;
        nextIdx       = wordIdx + DumpLenWidth'(1);
        dmemRdCe      = 1'b0;
        dmemRdAddress = '0;
        done          = 1'b0;
        case (state)
            RD_IDLE: begin
                if (start) begin
                    wordIdxNext = '0;
                    stateNext   = (wordCount == '0) ? RD_DONE : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                dmemRdCe      = 1'b1;
                dmemRdAddress = wordIdx[AddressWidth_dmem-1:0];
                stateNext     = RD_WAIT;
            end
            RD_WAIT: begin
                dataNext  = dmemRdQ;
                validNext = 1'b1;
                stateNext = RD_HOLD;
            end
            RD_HOLD: begin
                if (dumpReady) begin
                    validNext = 1'b0;
                    if (nextIdx == wordCount) begin
                        stateNext = RD_DONE;
                    end else begin
                        // Issue the next read in the accept cycle: two cycles per word.
                        wordIdxNext   = nextIdx;
                        dmemRdCe      = 1'b1;
                        dmemRdAddress = nextIdx[AddressWidth_dmem-1:0];
                        stateNext     = RD_WAIT;
                    end
                end
            end
            RD_DONE: begin
                done      = 1'b1;
                stateNext = RD_IDLE;
            end
            default: stateNext = RD_IDLE;
        endcase
    end

    assign dbgState = state;

endmodule

// File: rtl/kernel_host_ctrl.sv
// Host-side sequencer for the RISC-V kernel: loads imem, starts the core,
// waits for ap_done under a watchdog, then streams dmem back to the host.
module kernel_host_ctrl
    import kernel_host_pkg::*;
#(
    parameter int imem_size     = 40,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 65535
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         cmd_start,
    input  logic [ProgLenWidth-1:0]      prog_len,
    input  logic [DumpLenWidth-1:0]      dump_len,
    input  logic                         prog_valid,
    output logic                         prog_ready,
    input  logic [DataWidth-1:0]         prog_data,
    output logic [AddressWidth_imem-1:0] imem_wr_address,
    output logic                         imem_wr_we,
    output logic [DataWidth-1:0]         imem_wr_d,
    output logic                         core_rst,
    output logic                         ap_start,
    input  logic                         ap_done,
    output logic [AddressWidth_dmem-1:0] dmem_rd_address,
    output logic                         dmem_rd_ce,
    input  logic [DataWidth-1:0]         dmem_rd_q,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic [DataWidth-1:0]         dump_data,
    output logic                         busy,
    output logic                         finished,
    output logic                         timeout,
    output logic [CycleCountWidth-1:0]   cycle_count,
    output hostState_t                   dbgState,
    output readState_t                   dbgReadState
);

    // Streams (prog, dump) use valid/ready: a word moves on a rising edge where
    // both are high; a raised valid keeps its data stable until that edge.

    localparam logic [ProgLenWidth-1:0]    ImemSizeLen  = ProgLenWidth'(imem_size);
    localparam logic [CycleCountWidth-1:0] TimeoutLimit = CycleCountWidth'(TimeoutCycles);

    hostState_t              state, stateNext;
    logic [ProgLenWidth-1:0] wordIdx, loadCount;
    logic [DumpLenWidth-1:0] dumpCount;
    logic                    beat, dumpStart, dumpDone, runTimeout;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        prog_ready = 1'b0;
        core_rst   = 1'b1;
        ap_start   = 1'b0;
        dumpStart  = 1'b0;
        runTimeout = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_start) stateNext = LOAD;
            end
            LOAD: begin
                prog_ready = (wordIdx != loadCount);
                if (wordIdx == loadCount) stateNext = START;
            end
            START: begin
                core_rst  = 1'b0;
                ap_start  = 1'b1;
                stateNext = RUN;
            end
            RUN: begin
                core_rst = 1'b0;
                // ap_done takes priority over a watchdog expiry in the same cycle.
                if (ap_done) begin
                    dumpStart = 1'b1;
                    stateNext = DUMP;
                end else if (cycle_count + CycleCountWidth'(1) == TimeoutLimit) begin
                    runTimeout = 1'b1;
                    stateNext  = FIN;
                end
            end
            DUMP: begin
                if (dumpDone) stateNext = FIN;
            end
            FIN: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wordIdx     <= '0;
            loadCount   <= '0;
            dumpCount   <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
        end else begin
            if (state == IDLE && cmd_start) begin
                loadCount   <= (prog_len > ImemSizeLen) ? ImemSizeLen : prog_len;
                dumpCount   <= dump_len;
                wordIdx     <= '0;
                cycle_count <= '0;
                timeout     <= 1'b0;
            end
            if (beat) wordIdx <= wordIdx + ProgLenWidth'(1);
            if (state == RUN) cycle_count <= cycle_count + CycleCountWidth'(1);
            if (runTimeout) timeout <= 1'b1;
        end
    end

    assign beat            = prog_ready && prog_valid;
    assign imem_wr_we      = beat;
    assign imem_wr_address = beat ? wordIdx[AddressWidth_imem-1:0] : '0;
    assign imem_wr_d       = beat ? prog_data : '0;
    assign busy            = (state != IDLE);
    assign finished        = (state == FIN);
    assign dbgState        = state;

    dump_reader #(
        .DataWidth(DataWidth)
    ) u_dumpReader (
        .clk          (ap_clk),
        .rstN         (ap_rst_n),
        .start        (dumpStart),
        .wordCount    (dumpCount),
        .dmemRdAddress(dmem_rd_address),
        .dmemRdCe     (dmem_rd_ce),
        .dmemRdQ      (dmem_rd_q),
        .dumpValid    (dump_valid),
        .dumpData     (dump_data),
        .dumpReady    (dump_ready),
        .done         (dumpDone),
        .dbgState     (dbgReadState)
    );

endmodule

// File: tb/tb_kernel_host_ctrl.sv
// Bench for kernel_host_ctrl: table-driven launches, randomized launches
// against a launch-level model, and hand sequences for reset and ignored starts.
module tb_kernel_host_ctrl;
    import kernel_host_pkg::*;

    localparam int DW       = 32;
    localparam int ImemSize = 40;
    localparam int Tmo      = 100;

    typedef struct {
        string name;
        int    progLen;
        int    dumpLen;
        int    doneAt;
        int    validPct;
        int    readyPct;
        bit    seqCheck;
        int    dataBase;
        int    expWrites;
        int    expCount;
        bit    expTimeout;
        int    expReads;
    } vec_t;

    typedef struct {
        int wr, rd, dm, sp, fp, pe, he;
    } base_t;

    logic                         ap_clk = 1'b0;
    logic                         ap_rst_n = 1'b0;
    logic                         cmd_start = 1'b0;
    logic [ProgLenWidth-1:0]      prog_len = '0;
    logic [DumpLenWidth-1:0]      dump_len = '0;
    logic                         prog_valid = 1'b0;
    logic                         prog_ready;
    logic [DW-1:0]                prog_data = '0;
    logic [AddressWidth_imem-1:0] imem_wr_address;
    logic                         imem_wr_we;
    logic [DW-1:0]                imem_wr_d;
    logic                         core_rst;
    logic                         ap_start;
    logic                         ap_done = 1'b0;
    logic [AddressWidth_dmem-1:0] dmem_rd_address;
    logic                         dmem_rd_ce;
    logic [DW-1:0]                dmem_rd_q = '0;
    logic                         dump_valid;
    logic                         dump_ready = 1'b0;
    logic [DW-1:0]                dump_data;
    logic                         busy;
    logic                         finished;
    logic                         timeout;
    logic [CycleCountWidth-1:0]   cycle_count;
    hostState_t                   dbgState;
    readState_t                   dbgReadState;

    kernel_host_ctrl #(
        .imem_size    (ImemSize),
        .DataWidth    (DW),
        .TimeoutCycles(Tmo)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .cmd_start      (cmd_start),
        .prog_len       (prog_len),
        .dump_len       (dump_len),
        .prog_valid     (prog_valid),
        .prog_ready     (prog_ready),
        .prog_data      (prog_data),
        .imem_wr_address(imem_wr_address),
        .imem_wr_we     (imem_wr_we),
        .imem_wr_d      (imem_wr_d),
        .core_rst       (core_rst),
        .ap_start       (ap_start),
        .ap_done        (ap_done),
        .dmem_rd_address(dmem_rd_address),
        .dmem_rd_ce     (dmem_rd_ce),
        .dmem_rd_q      (dmem_rd_q),
        .dump_valid     (dump_valid),
        .dump_ready     (dump_ready),
        .dump_data      (dump_data),
        .busy           (busy),
        .finished       (finished),
        .timeout        (timeout),
        .cycle_count    (cycle_count),
        .dbgState       (dbgState),
        .dbgReadState   (dbgReadState)
    );

    // clock / reset
    always #5 ap_clk = ~ap_clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got=running required=done");
        $fatal(1, "watchdog");
    end

    // knobs set by the main sequence while the DUT is idle
    logic [DW-1:0] progWords[$];
    logic [DW-1:0] dmemModel[32];
    int progPct = 100, readyPct = 100, doneAt = 1000, beatBase = 0;

    // logs written only by the monitor
    int wrAddrQ[$], wrCycQ[$], rdAddrQ[$];
    logic [DW-1:0] wrDataQ[$], dumpGotQ[$];
    int beatCount = 0, startPulses = 0, finPulses = 0, protoErrs = 0, holdErrs = 0, cyc = 0;
    bit holdPending = 0;
    logic [DW-1:0] holdData = '0;

    int total = 0, bad = 0;

    // host program-stream driver
    always begin
        int idx;
        @(posedge ap_clk); #1;
        idx = beatCount - beatBase;
        prog_valid = (idx < progWords.size()) && (int'($urandom_range(0, 99)) < progPct);
        prog_data  = prog_valid ? progWords[idx] : DW'($urandom);
    end

    // host dump-stream sink
    always begin
        @(posedge ap_clk); #1;
        dump_ready = int'($urandom_range(0, 99)) < readyPct;
    end

    // kernel: raises ap_done in RUN cycle doneAt, counting from ap_start
    always begin
        int runCnt;
        @(posedge ap_clk); #1;
        if (core_rst) begin
            runCnt  = 0;
            ap_done = 1'b0;
        end else begin
            runCnt++;
            ap_done = runCnt > doneAt;
        end
    end

    // dmem port B, one-cycle read latency
    always @(posedge ap_clk) begin
        if (dmem_rd_ce) dmem_rd_q <= dmemModel[dmem_rd_address];
    end

    // monitor
    always @(negedge ap_clk) begin
        cyc++;
        if (ap_rst_n) begin
            if (imem_wr_we !== (prog_valid && prog_ready)) protoErrs++;
            if (prog_valid && prog_ready) beatCount++;
            if (imem_wr_we) begin
                wrAddrQ.push_back(int'(imem_wr_address));
                wrDataQ.push_back(imem_wr_d);
                wrCycQ.push_back(cyc);
            end
            if (dmem_rd_ce) rdAddrQ.push_back(int'(dmem_rd_address));
            if (ap_start) startPulses++;
            if (finished) finPulses++;
            if (holdPending && (!dump_valid || dump_data !== holdData)) holdErrs++;
            if (dump_valid && dump_ready) dumpGotQ.push_back(dump_data);
            holdPending = dump_valid && !dump_ready;
            holdData    = dump_data;
        end else begin
            holdPending = 0;
        end
    end

    task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mkVec(string n, int pl, int dl, int da, int vp, int rp, bit sq,
                                   int db, int ew, int ec, bit et, int er);
        vec_t v;
        v.name = n; v.progLen = pl; v.dumpLen = dl; v.doneAt = da;
        v.validPct = vp; v.readyPct = rp; v.seqCheck = sq; v.dataBase = db;
        v.expWrites = ew; v.expCount = ec; v.expTimeout = et; v.expReads = er;
        return v;
    endfunction

    // launch-level reference: what a launch must produce, from its inputs alone
    function automatic vec_t modelVec(string n, int pl, int dl, int da, int vp, int rp);
        bit et;
        et = da > Tmo;
        return mkVec(n, pl, dl, da, vp, rp, 1'b0, 0, (pl > ImemSize) ? ImemSize : pl,
                     et ? Tmo : da, et, et ? 0 : dl);
    endfunction

    task automatic prepVec(input vec_t v, output base_t b);
        @(negedge ap_clk);
        progWords.delete();
        for (int i = 0; i < v.progLen; i++)
            progWords.push_back((v.dataBase != 0) ? DW'(v.dataBase + i) : DW'($urandom));
        for (int i = 0; i < 32; i++) dmemModel[i] = DW'($urandom);
        progPct  = v.validPct;
        readyPct = v.readyPct;
        doneAt   = v.doneAt;
        beatBase = beatCount;
        b.wr = wrAddrQ.size(); b.rd = rdAddrQ.size(); b.dm = dumpGotQ.size();
        b.sp = startPulses; b.fp = finPulses; b.pe = protoErrs; b.he = holdErrs;
        @(posedge ap_clk); #1;
        prog_len  = ProgLenWidth'(v.progLen);
        dump_len  = DumpLenWidth'(v.dumpLen);
        cmd_start = 1'b1;
        @(posedge ap_clk); #1;
        cmd_start = 1'b0;
        @(negedge ap_clk);
        checkVal({v.name, ".launch_busy"}, busy, 1'b1);
        checkVal({v.name, ".launch_timeout_clr"}, timeout, 1'b0);
        checkVal({v.name, ".launch_count_clr"}, cycle_count, 0);
    endtask

    task automatic waitIdle(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge ap_clk);
            if (finished) ok = 1;
        end
        checkVal({name, ".finished_seen"}, ok, 1'b1);
        @(negedge ap_clk);
        checkVal({name, ".idle_after_fin"}, busy, 1'b0);
    endtask

    task automatic checkVec(input vec_t v, input base_t b);
        logic [DW-1:0] expQ[$];
        int n;
        checkVal({v.name, ".writes"}, wrAddrQ.size() - b.wr, v.expWrites);
        for (int i = 0; i < v.expWrites && b.wr + i < wrAddrQ.size(); i++) begin
            checkVal({v.name, ".wr_addr"}, wrAddrQ[b.wr + i], i);
            checkVal({v.name, ".wr_data"}, wrDataQ[b.wr + i], progWords[i]);
            if (v.seqCheck && i > 0)
                checkVal({v.name, ".wr_back2back"}, wrCycQ[b.wr + i] - wrCycQ[b.wr + i - 1], 1);
        end
        checkVal({v.name, ".ap_start_pulses"}, startPulses - b.sp, 1);
        checkVal({v.name, ".finished_pulses"}, finPulses - b.fp, 1);
        checkVal({v.name, ".cycle_count"}, cycle_count, v.expCount);
        checkVal({v.name, ".timeout"}, timeout, v.expTimeout);
        checkVal({v.name, ".reads"}, rdAddrQ.size() - b.rd, v.expReads);
        for (int i = 0; i < v.expReads && b.rd + i < rdAddrQ.size(); i++)
            checkVal({v.name, ".rd_addr"}, rdAddrQ[b.rd + i], i);
        for (int i = 0; i < v.expReads; i++) expQ.push_back(dmemModel[i]);
        checkVal({v.name, ".dump_beats"}, dumpGotQ.size() - b.dm, expQ.size());
        n = b.dm;
        while (expQ.size() > 0 && n < dumpGotQ.size()) begin
            checkVal({v.name, ".dump_word"}, dumpGotQ[n], expQ.pop_front());
            n++;
        end
        checkVal({v.name, ".write_protocol"}, protoErrs - b.pe, 0);
        checkVal({v.name, ".dump_hold_stable"}, holdErrs - b.he, 0);
    endtask

    task automatic runVec(input vec_t v);
        base_t b;
        prepVec(v, b);
        waitIdle(v.name);
        checkVec(v, b);
    endtask

    vec_t vecs[6];

    initial begin
        vec_t  v;
        base_t b;
        bit    seen;

        vecs[0] = mkVec("basic",   5,  4,   20, 100, 100, 1, 'h11,  5,  20, 0,  4);
        vecs[1] = mkVec("timeout", 6,  4, 1000, 100, 100, 0, 0,     6, 100, 1,  0);
        vecs[2] = mkVec("clip",   50,  8,   10, 100, 100, 1, 'h100, 40, 10, 0,  8);
        vecs[3] = mkVec("tie",     3,  2,  100, 100, 100, 0, 0,     3, 100, 0,  2);
        vecs[4] = mkVec("stall",  40, 32,   50,  70,  70, 0, 0,    40,  50, 0, 32);
        vecs[5] = mkVec("quick",   1,  1,    1, 100, 100, 0, 0,     1,   1, 0,  1);

        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        checkVal("rst.state", dbgState, IDLE);
        checkVal("rst.core_rst", core_rst, 1'b1);
        checkVal("rst.busy", busy, 1'b0);
        checkVal("rst.prog_ready", prog_ready, 1'b0);
        checkVal("rst.ap_start", ap_start, 1'b0);
        checkVal("rst.imem_wr_we", imem_wr_we, 1'b0);
        checkVal("rst.dmem_rd_ce", dmem_rd_ce, 1'b0);
        checkVal("rst.dump_valid", dump_valid, 1'b0);
        checkVal("rst.dump_data", dump_data, 0);
        checkVal("rst.finished", finished, 1'b0);
        checkVal("rst.timeout", timeout, 1'b0);
        checkVal("rst.cycle_count", cycle_count, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;

        for (int i = 0; i < 6; i++) runVec(vecs[i]);

        for (int i = 0; i < 8; i++) begin
            v = modelVec("rand", int'($urandom_range(0, 50)), int'($urandom_range(0, 32)),
                         int'($urandom_range(1, 110)), int'($urandom_range(60, 100)),
                         int'($urandom_range(60, 100)));
            runVec(v);
        end

        // reset while a dump word is held
        v = mkVec("rstdump", 2, 3, 5, 100, 0, 0, 0, 2, 5, 0, 3);
        prepVec(v, b);
        seen = 0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge ap_clk);
            if (dump_valid) seen = 1;
        end
        checkVal("rstdump.reach_hold", seen, 1'b1);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        checkVal("rstdump.still_held", dump_valid, 1'b1);
        @(negedge ap_clk);
        checkVal("rstdump.state", dbgState, IDLE);
        checkVal("rstdump.reader_state", dbgReadState, RD_IDLE);
        checkVal("rstdump.dump_valid", dump_valid, 1'b0);
        checkVal("rstdump.core_rst", core_rst, 1'b1);
        checkVal("rstdump.busy", busy, 1'b0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        readyPct = 100;
        repeat (3) @(negedge ap_clk);
        checkVal("rstdump.no_restart", busy, 1'b0);
        checkVal("rstdump.writes", wrAddrQ.size() - b.wr, 2);

        // cmd_start during RUN must be ignored
        v = mkVec("midrun", 4, 2, 30, 100, 100, 0, 0, 4, 30, 0, 2);
        prepVec(v, b);
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge ap_clk);
            if (busy && !core_rst && !ap_start) seen = 1;
        end
        checkVal("midrun.reach_run", seen, 1'b1);
        @(posedge ap_clk); #1;
        prog_len  = ProgLenWidth'(10);
        dump_len  = DumpLenWidth'(9);
        cmd_start = 1'b1;
        @(posedge ap_clk); #1;
        cmd_start = 1'b0;
        waitIdle(v.name);
        checkVec(v, b);

        // zero-length load and dump
        runVec(mkVec("zero", 0, 0, 7, 100, 100, 0, 0, 0, 7, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
